alu_acc_mc: RTL and testbench
=============================

ALU_ACC_MC -- requirements
Module: alu_acc_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result/accumulator width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports A, B  input  WIDTH  unsigned operands, sampled only on an accepted command.
REQ-005 SHALL have port ALU_Sel  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 ADDA, 5 MULA, 6 MAC, 7 ROL, 8 ROR, 9 AND, A OR, B XOR, C NAND, D ETH, E GTH, F LTH.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the command handshake; accept = in_valid && in_ready.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake; drain = out_valid && out_ready.
REQ-008 SHALL have port ALU_out  output  WIDTH  registered result.
REQ-009 SHALL have port flags  output  4  registered {ERR, V, C, Z}, MSB first.
REQ-010 SHALL have port busy  output  1  high while the divider FSM is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE and DIV; reset enters IDLE.
REQ-012 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-013 Every opcode except DIV with nonzero B SHALL complete in 1 cycle: ALU_out, flags and out_valid=1 are registered on the edge that accepts the command.
REQ-014 DIV with B!=0 SHALL enter DIV, run a restoring shift-subtract for exactly WIDTH cycles, then register quotient to ALU_out with out_valid=1; total latency WIDTH+1 cycles from accept.
REQ-015 DIV with B==0 SHALL complete in 1 cycle with ALU_out all-ones and ERR=1.
REQ-016 Internal accumulator acc (WIDTH) SHALL load every produced result, so ADDA = acc+A, MULA = acc*A, MAC = acc+A*B use the previous result.
REQ-017 All arithmetic SHALL be unsigned and truncated to WIDTH; ETH/GTH/LTH SHALL give all-ones when true, zero when false.
REQ-018 ROL/ROR SHALL rotate A by one bit; C = bit rotated out.
REQ-019 Z SHALL be 1 when the result is zero; C = carry out (ADD, ADDA, MAC) or borrow (SUB), else 0; V = 1 when truncated product bits are nonzero (MUL, MULA, MAC), else 0; ERR = 1 only per REQ-015/REQ-028.
REQ-020 ALU_out and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Drain without new result SHALL clear out_valid next cycle; drain and accept in the same cycle SHALL keep out_valid=1 with the new value (1-cycle ops).
REQ-022 A drain during DIV SHALL clear out_valid; the pending divide is unaffected.
REQ-023 in_valid while in_ready=0 SHALL be ignored; A, B, ALU_Sel changes during DIV SHALL not affect the quotient.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set state=IDLE, acc=0, ALU_out=0, flags=0, out_valid=0, busy=0, clearing any in-progress divide.
REQ-025 in_ready SHALL be 0 in any cycle where rst_n=0.
REQ-026 First command SHALL be acceptable on the first edge after rst_n returns high.

Configuration
REQ-027 Macro ALU_DIV_EN defined SHALL compile the iterative divider and DIV state per REQ-014/REQ-015.
REQ-028 Without ALU_DIV_EN, DIV SHALL complete in 1 cycle with ALU_out=0, ERR=1, acc loaded with 0; FSM never leaves IDLE; busy constant 0.

Verification (WIDTH=8, ALU_DIV_EN defined unless stated)
REQ-029 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=0, ALU_out=0x00, flags=0.
REQ-030 ADD A=200,B=100, out_ready=1 -> next cycle ALU_out=0x2C, C=1, Z=0, out_valid=1.
REQ-031 ADD 1+2 then MAC A=4,B=5 -> results 0x03 then 0x17; MULA A=16 next -> 0x70, V=1.
REQ-032 DIV A=100,B=7 -> busy=1 and in_ready=0 for 8 cycles, ALU_out=0x0E on cycle 9; DIV A=5,B=0 -> ALU_out=0xFF, ERR=1 in 1 cycle.
REQ-033 Backpressure: out_ready=0, issue XOR 0xF0,0x3C -> ALU_out=0xCC held, in_ready=0; raise out_ready with new AND command -> back-to-back results, no loss.
REQ-034 rst_n=0 on cycle 4 of a DIV -> busy=0, out_valid=0 next cycle; without ALU_DIV_EN, DIV 100/7 -> ALU_out=0x00, ERR=1, latency 1.

Source files
------------

// File: rtl/alu_acc_mc.sv
// alu_acc_mc: accumulator ALU with valid/ready command and result handshakes.
// Ports: clk, rst_n, A, B, ALU_Sel, in_valid/in_ready, out_valid/out_ready,
//   ALU_out, flags {ERR,V,C,Z}, busy. Define ALU_DIV_EN for the iterative divider.
module alu_acc_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_ADDA = 4'h4;
  localparam logic [3:0] OP_MULA = 4'h5;
  localparam logic [3:0] OP_MAC  = 4'h6;
  localparam logic [3:0] OP_ROL  = 4'h7;
  localparam logic [3:0] OP_ROR  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_ETH  = 4'hD;
  localparam logic [3:0] OP_GTH  = 4'hE;
  localparam logic [3:0] OP_LTH  = 4'hF;

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_out;
  logic [3:0]     r_flags;
  logic           r_ovalid;
  logic           w_accept;
  logic           w_drain;
  logic           w_div_start;
  logic           w_div_last;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W:0]     w_adda;
  logic [W:0]     w_mac;
  logic [2*W-1:0] w_mul;
  logic [2*W-1:0] w_mula;
  logic [W-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic           w_e;
  logic [3:0]     w_flg;

  assign in_ready = rst_n && (r_state == S_IDLE)
                    && (!r_ovalid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_ovalid && out_ready;

  assign out_valid = r_ovalid;
  assign ALU_out   = r_out;
  assign flags     = r_flags;

  assign w_add  = {1'b0, A} + {1'b0, B};
  assign w_sub  = {1'b0, A} - {1'b0, B};
  assign w_adda = {1'b0, r_acc} + {1'b0, A};
  assign w_mul  = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  assign w_mula = {{W{1'b0}}, r_acc} * {{W{1'b0}}, A};
  assign w_mac  = {1'b0, r_acc} + {1'b0, w_mul[W-1:0]};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_e   = 1'b0;
    unique case (ALU_Sel)
      OP_ADD:  begin w_res = w_add[W-1:0]; w_c = w_add[W]; end
      OP_SUB:  begin w_res = w_sub[W-1:0]; w_c = w_sub[W]; end
      OP_MUL:  begin
        w_res = w_mul[W-1:0];
        w_v   = |w_mul[2*W-1:W];
      end
      OP_DIV:  begin
`ifdef ALU_DIV_EN
        // Only the divide-by-zero case completes here.
        w_res = '1;
`else
        w_res = '0;
`endif
        w_e = 1'b1;
      end
      OP_ADDA: begin w_res = w_adda[W-1:0]; w_c = w_adda[W]; end
      OP_MULA: begin
        w_res = w_mula[W-1:0];
        w_v   = |w_mula[2*W-1:W];
      end
      OP_MAC:  begin
        w_res = w_mac[W-1:0];
        w_c   = w_mac[W];
        w_v   = |w_mul[2*W-1:W];
      end
      OP_ROL:  begin w_res = {A[W-2:0], A[W-1]}; w_c = A[W-1]; end
      OP_ROR:  begin w_res = {A[0], A[W-1:1]}; w_c = A[0]; end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NAND: w_res = ~(A & B);
      OP_ETH:  w_res = {W{A == B}};
      OP_GTH:  w_res = {W{A > B}};
      OP_LTH:  w_res = {W{A < B}};
    endcase
  end

  assign w_flg = {w_e, w_v, w_c, (w_res == '0)};

`ifdef ALU_DIV_EN
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_sh;
  logic [W:0]    w_df;
  logic          w_ge;
  logic [W-1:0]  w_quo_n;

  // Remainder stays below the divisor, so the trial difference
  // sign bit is a clean "does not fit" indicator.
  assign w_sh    = {r_rem, r_quo[W-1]};
  assign w_df    = w_sh - {1'b0, r_dvs};
  assign w_ge    = !w_df[W];
  assign w_quo_n = {r_quo[W-2:0], w_ge};

  assign w_div_start = w_accept && (ALU_Sel == OP_DIV)
                       && (B != '0);
  assign w_div_last  = (r_state == S_DIV)
                       && (r_cnt == CW'(W-1));
  assign busy = (r_state == S_DIV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (w_div_start) begin
      r_quo <= A;
      r_rem <= '0;
      r_dvs <= B;
      r_cnt <= '0;
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_n;
      r_rem <= w_ge ? w_df[W-1:0] : w_sh[W-1:0];
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_div_start = 1'b0;
  assign w_div_last  = 1'b0;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: if (w_div_start) w_state_n = S_DIV;
      S_DIV:  if (w_div_last)  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_out    <= '0;
      r_flags  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_drain) r_ovalid <= 1'b0;
      if (w_accept && !w_div_start) begin
        r_out    <= w_res;
        r_flags  <= w_flg;
        r_acc    <= w_res;
        r_ovalid <= 1'b1;
      end
`ifdef ALU_DIV_EN
      if (w_div_last) begin
        r_out    <= w_quo_n;
        r_flags  <= {3'b000, (w_quo_n == '0)};
        r_acc    <= w_quo_n;
        r_ovalid <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_acc_mc.sv
// tb_alu_acc_mc: directed + random checks of alu_acc_mc
// against an arithmetic reference model (WIDTH=8).
module tb_alu_acc_mc;
  localparam int W = 8;
  localparam int M = 256;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ALU_out;
  logic [3:0]   flags;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int m_acc = 0;

  alu_acc_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B),
    .ALU_Sel(ALU_Sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_out(ALU_out),
    .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int op, input int a,
                                input int b, input int acc,
                                output int res,
                                output logic [3:0] fl);
    longint r;
    longint p;
    logic c, v, e;
    c = 0; v = 0; e = 0; r = 0;
    case (op)
      0: begin r = a + b; c = (r >= M); end
      1: begin r = a - b + M; c = (a < b); end
      2: begin r = a * b; v = (r >= M); end
      3: begin
        e = 1;
        if (b == 0) r = DIV_EN ? M - 1 : 0;
        else if (DIV_EN) begin r = a / b; e = 0; end
      end
      4: begin r = acc + a; c = (r >= M); end
      5: begin r = acc * a; v = (r >= M); end
      6: begin
        p = a * b;
        v = (p >= M);
        r = acc + (p % M);
        c = (r >= M);
      end
      7: begin r = (a * 2) % M + a / (M / 2); c = (a >= M / 2); end
      8: begin r = a / 2 + (a % 2) * (M / 2); c = (a % 2 == 1); end
      9:  r = a & b;
      10: r = a | b;
      11: r = a ^ b;
      12: r = (M - 1) - (a & b);
      13: r = (a == b) ? M - 1 : 0;
      14: r = (a > b) ? M - 1 : 0;
      default: r = (a < b) ? M - 1 : 0;
    endcase
    res = int'(r % M);
    fl = {e, v, c, (res == 0)};
  endfunction

  task automatic do_op(input int op, input int a, input int b);
    int r;
    logic [3:0] f;
    ALU_Sel = op[3:0];
    A = a[W-1:0];
    B = b[W-1:0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_ready", in_ready, 1);
    model(op, a, b, m_acc, r, f);
    tick();
    in_valid = 1'b0;
    if (DIV_EN && op == 3 && b != 0) begin
      for (int i = 0; i < W; i++) begin
        chk("div_busy", busy, 1);
        chk("div_rdy", in_ready, 0);
        chk("div_ov", out_valid, 0);
        in_valid = 1'b1;
        A = 8'($urandom);
        B = 8'($urandom);
        ALU_Sel = 4'($urandom);
        tick();
      end
      in_valid = 1'b0;
    end
    chk("ov", out_valid, 1);
    chk("out", ALU_out, r);
    chk("flags", flags, f);
    m_acc = r;
  endtask

  initial begin
    int op, a, b;
    in_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_out", ALU_out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    m_acc = 0;

    do_op(0, 200, 100);
    chk("add_out", ALU_out, 8'h2C);
    chk("add_flags", flags, 4'b0010);
    do_op(0, 1, 2);
    chk("add2", ALU_out, 8'h03);
    do_op(6, 4, 5);
    chk("mac", ALU_out, 8'h17);
    do_op(5, 16, 0);
    chk("mula", ALU_out, 8'h70);
    chk("mula_flags", flags, 4'b0100);

    do_op(3, 100, 7);
    chk("div", ALU_out, DIV_EN ? 8'h0E : 8'h00);
    chk("div_flags", flags, DIV_EN ? 4'b0000 : 4'b1001);
    do_op(3, 5, 0);
    chk("div0", ALU_out, DIV_EN ? 8'hFF : 8'h00);
    chk("div0_flags", flags, DIV_EN ? 4'b1000 : 4'b1001);

    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_ov", out_valid, 0);
    out_ready = 1'b0;
    ALU_Sel = 4'hB;
    A = 8'hF0;
    B = 8'h3C;
    in_valid = 1'b1;
    #1;
    chk("bp_rdy0", in_ready, 1);
    tick();
    m_acc = 8'hCC;
    ALU_Sel = 4'h9;
    A = 8'hAA;
    B = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", in_ready, 0);
      chk("bp_ov", out_valid, 1);
      chk("bp_out", ALU_out, 8'hCC);
      chk("bp_flags", flags, 4'b0000);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_ov", out_valid, 1);
    chk("b2b_out", ALU_out, 8'h0A);
    m_acc = 8'h0A;
    tick();
    chk("b2b_drain", out_valid, 0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, M - 1);
      b = ($urandom_range(0, 7) == 0) ? 0
          : $urandom_range(0, M - 1);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        chk("idle_hold", ALU_out, m_acc);
      end
      do_op(op, a, b);
    end

    ALU_Sel = 4'h3;
    A = 8'd100;
    B = 8'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, DIV_EN ? 1 : 0);
    rst_n = 1'b0;
    #1;
    chk("rst_rdy2", in_ready, 0);
    tick();
    chk("rdiv_busy", busy, 0);
    chk("rdiv_ov", out_valid, 0);
    chk("rdiv_out", ALU_out, 0);
    chk("rdiv_flags", flags, 0);
    rst_n = 1'b1;
    m_acc = 0;
    do_op(4, 5, 0);
    chk("acc_clr", ALU_out, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
